kbd_queue: RTL and testbench

Keyboard-side producer for the processor's `keyboard_in` / `keyboard_ack` interface. It receives PS/2 frames from the board's keyboard connector, filters out key-release and extended-prefix bytes, and buffers key-press codes in a FIFO. It presents the oldest code on `keyboard_in` and pops it when the processor executes its keyboard-read instruction, which asserts `keyboard_ack` for one cycle.

---
 rtl/kbd_queue.sv | 178 +++++++++++++++++
 tb/tb_kbd_queue.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/kbd_queue.sv
// kbd_queue: PS/2 key-press receiver feeding a FIFO for the keyboard_in/keyboard_ack port.
// Define KBD_QUEUE_ASCII_EN to translate set-2 make codes to ASCII before queueing.
module kbd_queue #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        keyboard_ack,
  output logic [31:0] keyboard_in,
  output logic        key_valid,
  output logic        overflow,
  output logic        parity_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t          r_state;
  logic [1:0]      r_clk_sync;
  logic [1:0]      r_dat_sync;
  logic            r_clk_prev;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_par;
  logic [TW-1:0]   r_idle_cnt;
  logic            r_byte_vld;
  logic            r_parity_err;
  logic            r_break;
  logic            r_overflow;
  logic [7:0]      r_mem [DEPTH];
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;
  logic            w_fall;
  logic            w_dat;
  logic            w_is_e0;
  logic            w_is_f0;
  logic            w_make;
  logic            w_map_ok;
  logic [7:0]      w_code;
  logic            w_push_req;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic            w_full;
  assign w_fall = r_clk_prev & ~r_clk_sync[1];
  assign w_dat  = r_dat_sync[1];
  // Synchronisers idle high so reset release never fakes a falling edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
      r_clk_prev <= r_clk_sync[1];
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_idle_cnt   <= '0;
      r_byte_vld   <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      r_idle_cnt <= w_fall ? '0 : (r_idle_cnt == TW'(TIMEOUT) ? r_idle_cnt : r_idle_cnt + 1'b1);
      if (w_fall) begin
        case (r_state)
          IDLE: begin
            r_state   <= w_dat ? IDLE : DATA;
            r_bit_cnt <= '0;
          end
          DATA: begin
            r_shift   <= {w_dat, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_state   <= (r_bit_cnt == 3'd7) ? PARITY : DATA;
          end
          PARITY: begin
            r_par   <= w_dat;
            r_state <= STOP;
          end
          default: begin
            r_state      <= IDLE;
            r_byte_vld   <= w_dat & (^{r_shift, r_par});
            r_parity_err <= r_parity_err | ~(^{r_shift, r_par});
          end
        endcase
      end else if (r_state != IDLE && r_idle_cnt == TW'(TIMEOUT)) begin
        r_state <= IDLE;
      end
    end
  end
`ifdef KBD_QUEUE_ASCII_EN
  function automatic logic [8:0] f_ascii(input logic [7:0] c);
    case (c)
      8'h1C: f_ascii = {1'b1, 8'h61};
      8'h32: f_ascii = {1'b1, 8'h62};
      8'h21: f_ascii = {1'b1, 8'h63};
      8'h23: f_ascii = {1'b1, 8'h64};
      8'h24: f_ascii = {1'b1, 8'h65};
      8'h2B: f_ascii = {1'b1, 8'h66};
      8'h34: f_ascii = {1'b1, 8'h67};
      8'h33: f_ascii = {1'b1, 8'h68};
      8'h43: f_ascii = {1'b1, 8'h69};
      8'h3B: f_ascii = {1'b1, 8'h6A};
      8'h42: f_ascii = {1'b1, 8'h6B};
      8'h4B: f_ascii = {1'b1, 8'h6C};
      8'h3A: f_ascii = {1'b1, 8'h6D};
      8'h31: f_ascii = {1'b1, 8'h6E};
      8'h44: f_ascii = {1'b1, 8'h6F};
      8'h4D: f_ascii = {1'b1, 8'h70};
      8'h15: f_ascii = {1'b1, 8'h71};
      8'h2D: f_ascii = {1'b1, 8'h72};
      8'h1B: f_ascii = {1'b1, 8'h73};
      8'h2C: f_ascii = {1'b1, 8'h74};
      8'h3C: f_ascii = {1'b1, 8'h75};
      8'h2A: f_ascii = {1'b1, 8'h76};
      8'h1D: f_ascii = {1'b1, 8'h77};
      8'h22: f_ascii = {1'b1, 8'h78};
      8'h35: f_ascii = {1'b1, 8'h79};
      8'h1A: f_ascii = {1'b1, 8'h7A};
      8'h45: f_ascii = {1'b1, 8'h30};
      8'h16: f_ascii = {1'b1, 8'h31};
      8'h1E: f_ascii = {1'b1, 8'h32};
      8'h26: f_ascii = {1'b1, 8'h33};
      8'h25: f_ascii = {1'b1, 8'h34};
      8'h2E: f_ascii = {1'b1, 8'h35};
      8'h36: f_ascii = {1'b1, 8'h36};
      8'h3D: f_ascii = {1'b1, 8'h37};
      8'h3E: f_ascii = {1'b1, 8'h38};
      8'h46: f_ascii = {1'b1, 8'h39};
      8'h29: f_ascii = {1'b1, 8'h20};
      8'h5A: f_ascii = {1'b1, 8'h0D};
      8'h66: f_ascii = {1'b1, 8'h08};
      default: f_ascii = 9'h000;
    endcase
  endfunction
  assign {w_map_ok, w_code} = f_ascii(r_shift);
`else
  assign w_map_ok = 1'b1;
  assign w_code   = r_shift;
`endif
  assign w_is_e0    = r_shift == 8'hE0;
  assign w_is_f0    = r_shift == 8'hF0;
  assign w_make     = r_byte_vld & ~w_is_e0 & ~w_is_f0 & ~r_break;
  assign w_push_req = w_make & w_map_ok;
  assign w_empty    = r_wptr == r_rptr;
  assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop      = keyboard_ack & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push     = w_push_req & (~w_full | w_pop);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_break    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wptr     <= w_push ? r_wptr + 1'b1 : r_wptr;
      r_rptr     <= w_pop ? r_rptr + 1'b1 : r_rptr;
      r_break    <= (r_byte_vld & ~w_is_e0) ? w_is_f0 : r_break;
      r_overflow <= r_overflow | (w_push_req & ~w_push);
    end
  end
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_code;
  end
  assign keyboard_in = w_empty ? 32'd0 : {24'b0, r_mem[r_rptr[AW-1:0]]};
  assign key_valid   = ~w_empty;
  assign overflow    = r_overflow;
  assign parity_err  = r_parity_err;
endmodule

// File: tb/tb_kbd_queue.sv
// tb_kbd_queue: directed and randomized PS/2 frames checked against a queue-based model.
module tb_kbd_queue;
  localparam int DEPTH = 16;
  localparam int TMO   = 200;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        keyboard_ack = 1'b0;
  logic [31:0] keyboard_in;
  logic        key_valid;
  logic        overflow;
  logic        parity_err;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  q[$];
  bit          m_brk, m_ovf, m_perr;
  kbd_queue #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyboard_ack(keyboard_ack), .keyboard_in(keyboard_in), .key_valid(key_valid),
    .overflow(overflow), .parity_err(parity_err)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int m_map(input logic [7:0] c);
`ifdef KBD_QUEUE_ASCII_EN
    case (c)
      8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63; 8'h23: return 8'h64;
      8'h24: return 8'h65; 8'h2B: return 8'h66; 8'h34: return 8'h67; 8'h33: return 8'h68;
      8'h43: return 8'h69; 8'h3B: return 8'h6A; 8'h42: return 8'h6B; 8'h4B: return 8'h6C;
      8'h3A: return 8'h6D; 8'h31: return 8'h6E; 8'h44: return 8'h6F; 8'h4D: return 8'h70;
      8'h15: return 8'h71; 8'h2D: return 8'h72; 8'h1B: return 8'h73; 8'h2C: return 8'h74;
      8'h3C: return 8'h75; 8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
      8'h35: return 8'h79; 8'h1A: return 8'h7A;
      8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32; 8'h26: return 8'h33;
      8'h25: return 8'h34; 8'h2E: return 8'h35; 8'h36: return 8'h36; 8'h3D: return 8'h37;
      8'h3E: return 8'h38; 8'h46: return 8'h39;
      8'h29: return 8'h20; 8'h5A: return 8'h0D; 8'h66: return 8'h08;
      default: return -1;
    endcase
`else
    return int'(c);
`endif
  endfunction
  function automatic logic [31:0] m_head();
    return (q.size() != 0) ? {24'b0, q[0]} : 32'd0;
  endfunction
  task automatic model_frame(input logic [7:0] b, input bit pbad, input bit sbad, input bit ack);
    int code;
    if (ack && q.size() != 0) void'(q.pop_front());
    if (pbad) m_perr = 1;
    else if (!sbad) begin
      if (b == 8'hE0) ;
      else if (b == 8'hF0) m_brk = 1;
      else if (m_brk) m_brk = 0;
      else begin
        code = m_map(b);
        if (code >= 0) begin
          if (q.size() < DEPTH) q.push_back(code[7:0]);
          else m_ovf = 1;
        end
      end
    end
  endtask
  task automatic check_state(input string tag);
    chk({tag, "_valid"}, {31'b0, key_valid}, {31'b0, q.size() != 0});
    chk({tag, "_head"}, keyboard_in, m_head());
    chk({tag, "_ovf"}, {31'b0, overflow}, {31'b0, m_ovf});
    chk({tag, "_perr"}, {31'b0, parity_err}, {31'b0, m_perr});
  endtask
  task automatic do_reset();
    reset = 1'b0;
    q.delete();
    m_brk = 0; m_ovf = 0; m_perr = 0;
    repeat (3) @(negedge clock);
    check_state("rst");
    reset = 1'b1;
    @(negedge clock);
  endtask
  task automatic pop_ack(input string tag);
    chk({tag, "_pophead"}, keyboard_in, m_head());
    keyboard_ack = 1'b1;
    @(negedge clock);
    keyboard_ack = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    chk({tag, "_after"}, keyboard_in, m_head());
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 1 && q.size() != 0; i++) pop_ack(tag);
    chk({tag, "_empty"}, {31'b0, key_valid}, 32'd0);
  endtask
  // Pin edges are driven at negedge; with ack_here the ack lands in the push cycle.
  task automatic ps2_bit(input logic b, input bit ack_here);
    ps2_data = b;
    repeat (3) @(negedge clock);
    ps2_clk = 1'b0;
    if (ack_here) begin
      repeat (3) @(negedge clock);
      chk("ack_head", keyboard_in, m_head());
      keyboard_ack = 1'b1;
      @(negedge clock);
      keyboard_ack = 1'b0;
      repeat (2) @(negedge clock);
    end else repeat (6) @(negedge clock);
    ps2_clk = 1'b1;
    repeat (3) @(negedge clock);
  endtask
  task automatic send_frame(input logic [7:0] b, input bit pbad, input bit sbad, input bit ack);
    logic par;
    par = ~(^b) ^ pbad;
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 0);
    ps2_bit(par, 0);
    ps2_bit(~sbad, ack);
    repeat (2) @(negedge clock);
    model_frame(b, pbad, sbad, ack);
  endtask
  initial begin
    logic [7:0] b;
    bit pb, sb, ak;
    do_reset();
    pop_ack("empty_ack");
    send_frame(8'h1C, 0, 0, 0);
    check_state("f1c");
    pop_ack("f1c");
    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'h75, 0, 0, 0);
    check_state("seq");
    drain("seq");
    send_frame(8'h1C, 1, 0, 0);
    check_state("par_bad");
    send_frame(8'h32, 0, 0, 0);
    check_state("par_ok");
    send_frame(8'h3C, 0, 1, 0);
    check_state("stop_bad");
    drain("par");
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) send_frame(8'h10 + 8'(i), 0, 0, 0);
    check_state("full");
    send_frame(8'h2B, 0, 0, 1);
    check_state("full_ack");
    drain("full");
    do_reset();
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0], 0);
    repeat (TMO + 20) @(negedge clock);
    check_state("tmo_idle");
    send_frame(8'h29, 0, 0, 0);
    check_state("tmo");
    drain("tmo");
    do_reset();
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(5))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'h1C;
        default: b = 8'($urandom);
      endcase
      pb = $urandom_range(7) == 0;
      sb = $urandom_range(9) == 0;
      ak = $urandom_range(5) == 0;
      send_frame(b, pb, sb, ak);
      check_state("rnd");
      repeat ($urandom_range(2)) pop_ack("rnd");
    end
    drain("rnd");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
